// File: rtl/ncsr_axil_master_pkg.sv
// rtl/ncsr_axil_master_pkg.sv - shared FSM encoding, opcodes and defaults for the CSR AXI-Lite initiator
package ncsr_axil_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_REQ  = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_RESP = 3'd4,
        ST_RSP     = 3'd5
    } ncsr_state_e;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    localparam int DEF_TIMEOUT_CYCLES = 1024;
    localparam int DEF_TO_CNT_WIDTH   = 16;

endpackage

// File: rtl/ncsr_axil_master_if.sv
// rtl/ncsr_axil_master_if.sv - AXI-Lite CSR bus bundle with initiator/target modports
`ifndef AXIL_DATA_WIDTH
`define AXIL_DATA_WIDTH 32
`endif
`ifndef AXIL_STRB_WIDTH
`define AXIL_STRB_WIDTH (`AXIL_DATA_WIDTH/8)
`endif

interface ncsr_axil_master_if #(
    parameter int ADDR_WIDTH = 20
);
    logic [ADDR_WIDTH-1:0]       awaddr_m;
    logic                        awvalid_m;
    logic                        awready_m;
    logic [`AXIL_DATA_WIDTH-1:0] wdata_m;
    logic [`AXIL_STRB_WIDTH-1:0] wstrb_m;
    logic                        wvalid_m;
    logic                        wready_m;
    logic                        bvalid_m;
    logic                        bready_m;
    logic [ADDR_WIDTH-1:0]       araddr_m;
    logic                        arvalid_m;
    logic                        arready_m;
    logic [`AXIL_DATA_WIDTH-1:0] rdata_m;
    logic                        rvalid_m;
    logic                        rready_m;

    modport master (
        output awaddr_m, awvalid_m, wdata_m, wstrb_m, wvalid_m, bready_m,
        output araddr_m, arvalid_m, rready_m,
        input  awready_m, wready_m, bvalid_m, arready_m, rdata_m, rvalid_m
    );

    modport slave (
        input  awaddr_m, awvalid_m, wdata_m, wstrb_m, wvalid_m, bready_m,
        input  araddr_m, arvalid_m, rready_m,
        output awready_m, wready_m, bvalid_m, arready_m, rdata_m, rvalid_m
    );
endinterface

// File: rtl/ncsr_resp_timer.sv
// rtl/ncsr_resp_timer.sv - response-wait counter; pulses expired on its last enabled cycle
module ncsr_resp_timer #(
    parameter int TO_CNT_WIDTH   = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam logic [TO_CNT_WIDTH-1:0] LAST = TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TO_CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + TO_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/ncsr_axil_master.sv
// rtl/ncsr_axil_master.sv - single-outstanding AXI-Lite CSR initiator with response timeout
// Optional stat counters enabled by NCSR_AXIL_MASTER_STATS_EN.
`ifndef AXIL_DATA_WIDTH
`define AXIL_DATA_WIDTH 32
`endif
`ifndef AXIL_STRB_WIDTH
`define AXIL_STRB_WIDTH (`AXIL_DATA_WIDTH/8)
`endif

module ncsr_axil_master
    import ncsr_axil_master_pkg::*;
#(
    parameter int AXIL_ADDR_WIDTH = 20,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int TO_CNT_WIDTH    = DEF_TO_CNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_wr,
    input  logic [AXIL_ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [`AXIL_DATA_WIDTH-1:0] cmd_wdata,
    input  logic [`AXIL_STRB_WIDTH-1:0] cmd_wstrb,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [`AXIL_DATA_WIDTH-1:0] rsp_rdata,
    output logic                        rsp_timeout,
`ifdef NCSR_AXIL_MASTER_STATS_EN
    output logic [31:0]                 stat_wr_cnt,
    output logic [31:0]                 stat_rd_cnt,
    output logic [31:0]                 stat_to_cnt,
`endif
    ncsr_axil_master_if.master          axil
);
    ncsr_state_e                 state_q, state_d;
    logic [AXIL_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [`AXIL_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [`AXIL_STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                        aw_done_q, aw_done_d;
    logic                        w_done_q, w_done_d;
    logic [`AXIL_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                        to_q, to_d;

    logic awvalid, wvalid, arvalid, bready, rready;
    logic aw_fire, w_fire;
    logic timer_en, timer_expired;

    assign timer_en = (state_q == ST_WR_RESP) || (state_q == ST_RD_RESP);

    ncsr_resp_timer #(
        .TO_CNT_WIDTH   (TO_CNT_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (!timer_en),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        to_d      = to_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        arvalid   = 1'b0;
        bready    = 1'b0;
        rready    = 1'b0;
        aw_fire   = 1'b0;
        w_fire    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Both ready lines stay high so late or stray responses are drained here.
                cmd_ready = 1'b1;
                bready    = 1'b1;
                rready    = 1'b1;
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
                    wstrb_d   = cmd_wstrb;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    case (cmd_wr)
                        CMD_WR: state_d = ST_WR_REQ;
                        CMD_RD: state_d = ST_RD_REQ;
                    endcase
                end
            end
            ST_WR_REQ: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                aw_fire = awvalid && axil.awready_m;
                w_fire  = wvalid && axil.wready_m;
                if (aw_fire) aw_done_d = 1'b1;
                if (w_fire)  w_done_d  = 1'b1;
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                bready = 1'b1;
                if (axil.bvalid_m) begin
                    rdata_d = '0;
                    to_d    = 1'b0;
                    state_d = ST_RSP;
                end else if (timer_expired) begin
                    rdata_d = '0;
                    to_d    = 1'b1;
                    state_d = ST_RSP;
                end
            end
            ST_RD_REQ: begin
                arvalid = 1'b1;
                if (axil.arready_m) state_d = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                rready = 1'b1;
                if (axil.rvalid_m) begin
                    rdata_d = axil.rdata_m;
                    to_d    = 1'b0;
                    state_d = ST_RSP;
                end else if (timer_expired) begin
                    rdata_d = '0;
                    to_d    = 1'b1;
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            to_q      <= to_d;
        end
    end

    assign rsp_rdata      = rdata_q;
    assign rsp_timeout    = to_q;
    assign axil.awaddr_m  = addr_q;
    assign axil.awvalid_m = awvalid;
    assign axil.wdata_m   = wdata_q;
    assign axil.wstrb_m   = wstrb_q;
    assign axil.wvalid_m  = wvalid;
    assign axil.bready_m  = bready;
    assign axil.araddr_m  = addr_q;
    assign axil.arvalid_m = arvalid;
    assign axil.rready_m  = rready;

`ifdef NCSR_AXIL_MASTER_STATS_EN
    logic [31:0] wr_cnt_q, rd_cnt_q, to_cnt_q;
    logic        rsp_entry;

    assign rsp_entry = (state_d == ST_RSP) && (state_q != ST_RSP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            to_cnt_q <= '0;
        end else if (rsp_entry) begin
            if (to_d) begin
                to_cnt_q <= to_cnt_q + 32'd1;
            end else if (state_q == ST_WR_RESP) begin
                wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    assign stat_wr_cnt = wr_cnt_q;
    assign stat_rd_cnt = rd_cnt_q;
    assign stat_to_cnt = to_cnt_q;
`endif

endmodule
